// File: rtl/addr_map_pkg.sv
// Shared definitions for the address-map pipeline: hash-mode encodings and
// the bank-id scrambling helpers applied in the second pipeline stage.
package addr_map_pkg;

  typedef enum logic [2:0] {
    HASH_IDENT = 3'd0,
    HASH_REV   = 3'd1,
    HASH_ROTL  = 3'd2,
    HASH_XOR   = 3'd3
  } hash_mode_e;

  // Helpers work on fixed-width carriers; callers pass the live width, so
  // bank ids up to 16 bits and in-bank addresses up to 64 bits are covered.
  localparam int FN_ID_W     = 16;
  localparam int FN_ID_IW    = $clog2(FN_ID_W);
  localparam int FN_LOCAL_W  = 64;
  localparam int FN_LOCAL_IW = $clog2(FN_LOCAL_W);

  function automatic logic [FN_ID_W-1:0] bit_reverse(input logic [FN_ID_W-1:0] v,
                                                     input int w);
    logic [FN_ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < FN_ID_W; i++) begin
      if (i < w) r[FN_ID_IW'(i)] = v[FN_ID_IW'(w - 1 - i)];
    end
    return r;
  endfunction

  function automatic logic [FN_ID_W-1:0] rotate_left1(input logic [FN_ID_W-1:0] v,
                                                      input int w);
    logic [FN_ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < FN_ID_W; i++) begin
      if (i < w) r[FN_ID_IW'((i + 1) % w)] = v[FN_ID_IW'(i)];
    end
    return r;
  endfunction

  // Bit i of the in-bank address lands in chunk bit (i mod w): this is the
  // XOR of all w-bit chunks with the top chunk zero-padded.
  function automatic logic [FN_ID_W-1:0] xor_fold(input logic [FN_LOCAL_W-1:0] v,
                                                  input int lw,
                                                  input int w);
    logic [FN_ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < FN_LOCAL_W; i++) begin
      if (i < lw) r[FN_ID_IW'(i % w)] = r[FN_ID_IW'(i % w)] ^ v[FN_LOCAL_IW'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/addr_map_pipe_stage.sv
// Single valid/ready register slice. Accepts a new payload when empty or when
// the current payload is being taken downstream in the same cycle.
module pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    valid_d  = valid_q;
    data_d   = data_q;
    in_ready = !valid_q || out_ready;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops
  // sample pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      // NOTE: the payload is reset too, so the outputs read zero after reset;
      // it is a single register, not a memory array.
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/addr_map_pipe.sv
// Two-stage handshaked global-address splitter: bank id (optionally hashed),
// in-bank address, range error, tag pass-through and a saturating error count.
module addr_map_pipe
  import addr_map_pkg::*;
#(
  parameter int ADDR_WIDTH       = 32,
  parameter int NUM_MODULES      = 8,
  parameter int MOD_ID_BITS      = 3,
  parameter int LOCAL_ADDR_WIDTH = 10,
  parameter int OFFSET_BITS      = 10,
  parameter int TAG_WIDTH        = 4,
  parameter int ERR_CNT_WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ADDR_WIDTH-1:0]       in_addr,
  input  logic [TAG_WIDTH-1:0]        in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [MOD_ID_BITS-1:0]      out_module_id,
  output logic [LOCAL_ADDR_WIDTH-1:0] out_local_addr,
  output logic [TAG_WIDTH-1:0]        out_tag,
  output logic                        out_err,
  input  logic                        cfg_wr,
  input  logic [2:0]                  cfg_hash_sel,
  output logic                        cfg_busy,
  output logic [2:0]                  cfg_active,
  output logic [ERR_CNT_WIDTH-1:0]    err_cnt,
  input  logic                        err_clr
);

  localparam int S1_W = ADDR_WIDTH + TAG_WIDTH;
  localparam int S2_W = MOD_ID_BITS + LOCAL_ADDR_WIDTH + TAG_WIDTH + 1;

  logic                        s1_in_ready, s1_valid, s2_in_ready, s2_valid;
  logic [S1_W-1:0]             s1_data;
  logic [S2_W-1:0]             s2_in_data, s2_data;
  logic [ADDR_WIDTH-1:0]       s1_addr, lo_mask;
  logic [TAG_WIDTH-1:0]        s1_tag;
  logic [MOD_ID_BITS-1:0]      mod_raw, mod_hash;
  logic [LOCAL_ADDR_WIDTH-1:0] local_addr;
  logic                        range_err;

  logic                     cfg_pending_q, cfg_pending_d;
  logic [2:0]               cfg_pend_val_q, cfg_pend_val_d;
  logic [2:0]               cfg_active_q, cfg_active_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  // ---------------- pipeline ----------------
  assign in_ready = !cfg_pending_q && s1_in_ready;

  pipe_stage #(.WIDTH(S1_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid && !cfg_pending_q),
    .in_ready  (s1_in_ready),
    .in_data   ({in_addr, in_tag}),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  pipe_stage #(.WIDTH(S2_W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_in_data),
    .out_valid (s2_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign {s1_addr, s1_tag} = s1_data;

  always_comb begin
    lo_mask    = (ADDR_WIDTH'(1) << OFFSET_BITS) - ADDR_WIDTH'(1);
    mod_raw    = MOD_ID_BITS'(s1_addr >> OFFSET_BITS);
    // Drop the bank field and close the gap: high part shifts down by M bits.
    local_addr = LOCAL_ADDR_WIDTH'(((s1_addr >> (OFFSET_BITS + MOD_ID_BITS)) << OFFSET_BITS)
                                   | (s1_addr & lo_mask));
    range_err  = |(s1_addr >> (LOCAL_ADDR_WIDTH + MOD_ID_BITS));

    mod_hash = mod_raw;
    case (cfg_active_q)
      HASH_REV:  mod_hash = MOD_ID_BITS'(bit_reverse(FN_ID_W'(mod_raw), MOD_ID_BITS));
      HASH_ROTL: mod_hash = MOD_ID_BITS'(rotate_left1(FN_ID_W'(mod_raw), MOD_ID_BITS));
      HASH_XOR:  mod_hash = mod_raw ^ MOD_ID_BITS'(xor_fold(FN_LOCAL_W'(local_addr),
                                                            LOCAL_ADDR_WIDTH, MOD_ID_BITS));
      default:   mod_hash = mod_raw;
    endcase

    if (range_err) begin
      s2_in_data = {{MOD_ID_BITS{1'b0}}, {LOCAL_ADDR_WIDTH{1'b0}}, s1_tag, 1'b1};
    end else begin
      s2_in_data = {mod_hash, local_addr, s1_tag, 1'b0};
    end
  end

  assign out_valid = s2_valid;
  assign {out_module_id, out_local_addr, out_tag, out_err} = s2_data;

  // ---------------- config ----------------
  // A write on the commit edge wins and keeps the change pending, so the
  // newest requested mode is the one that eventually becomes active.
  always_comb begin
    cfg_pending_d  = cfg_pending_q;
    cfg_pend_val_d = cfg_pend_val_q;
    cfg_active_d   = cfg_active_q;
    if (cfg_wr) begin
      cfg_pending_d  = 1'b1;
      cfg_pend_val_d = cfg_hash_sel;
    end else if (cfg_pending_q && !s1_valid && !s2_valid) begin
      cfg_active_d  = cfg_pend_val_q;
      cfg_pending_d = 1'b0;
    end
  end

  // ---------------- error counter ----------------
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (s2_valid && out_ready && out_err && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_pending_q  <= 1'b0;
      cfg_pend_val_q <= 3'd0;
      cfg_active_q   <= 3'd0;
      err_cnt_q      <= '0;
    end else begin
      cfg_pending_q  <= cfg_pending_d;
      cfg_pend_val_q <= cfg_pend_val_d;
      cfg_active_q   <= cfg_active_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign cfg_busy   = cfg_pending_q;
  assign cfg_active = cfg_active_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_addr_map_pipe.sv
// Scoreboard bench for addr_map_pipe: drivers push expected results, a
// negedge monitor pops and compares every accepted output beat.
module tb_addr_map_pipe;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_addr;
  logic [3:0]  in_tag, out_tag;
  logic [2:0]  out_module_id, cfg_hash_sel, cfg_active;
  logic [9:0]  out_local_addr;
  logic        out_err, cfg_wr, cfg_busy, err_clr;
  logic [15:0] err_cnt;

  // Second instance with a 2-bit error counter to reach saturation quickly.
  logic        sat_in_valid, sat_in_ready, sat_out_valid, sat_out_err, sat_cfg_busy;
  logic [31:0] sat_in_addr;
  logic [3:0]  sat_out_tag;
  logic [2:0]  sat_out_module_id, sat_cfg_active;
  logic [9:0]  sat_out_local_addr;
  logic [1:0]  sat_err_cnt;

  addr_map_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_module_id(out_module_id),
    .out_local_addr(out_local_addr), .out_tag(out_tag), .out_err(out_err),
    .cfg_wr(cfg_wr), .cfg_hash_sel(cfg_hash_sel), .cfg_busy(cfg_busy),
    .cfg_active(cfg_active), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  addr_map_pipe #(.ERR_CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sat_in_valid), .in_ready(sat_in_ready), .in_addr(sat_in_addr), .in_tag(4'd0),
    .out_valid(sat_out_valid), .out_ready(1'b1), .out_module_id(sat_out_module_id),
    .out_local_addr(sat_out_local_addr), .out_tag(sat_out_tag), .out_err(sat_out_err),
    .cfg_wr(1'b0), .cfg_hash_sel(3'd0), .cfg_busy(sat_cfg_busy),
    .cfg_active(sat_cfg_active), .err_cnt(sat_err_cnt), .err_clr(1'b0)
  );

  typedef struct packed {
    logic [2:0] mod;
    logic [9:0] loc;
    logic [3:0] tag;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, held;
  logic stalled;
  int   n_pass  = 0;
  int   n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("hold_stable", 32'({out_module_id, out_local_addr, out_tag, out_err}),
                         32'(held));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: tag %0d arrived with empty scoreboard", out_tag);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_module_id", 32'(out_module_id), 32'(mon_e.mod));
          check("out_local_addr", 32'(out_local_addr), 32'(mon_e.loc));
          check("out_tag", 32'(out_tag), 32'(mon_e.tag));
          check("out_err", 32'(out_err), 32'(mon_e.err));
        end
      end
      stalled = out_valid && !out_ready;
      held    = {out_module_id, out_local_addr, out_tag, out_err};
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [31:0] addr, input logic [3:0] tag, input logic [2:0] mod,
                      input logic [9:0] loc, input logic err);
    int   budget = 0;
    logic acc;
    exp_t e;
    in_valid = 1'b1;
    in_addr  = addr;
    in_tag   = tag;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!acc && budget < 200);
    if (acc) begin
      e = '{mod: mod, loc: loc, tag: tag, err: err};
      exp_q.push_back(e);
    end else begin
      check("accept_timeout", 32'(acc), 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int b = 0;
    while ((exp_q.size() != 0 || out_valid) && b < 200) begin
      @(posedge clk);
      #1;
      b++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_cfg_idle();
    int b = 0;
    while (cfg_busy && b < 200) begin
      @(posedge clk);
      #1;
      b++;
    end
    check("cfg_busy_clears", 32'(cfg_busy), 32'd0);
  endtask

  task automatic set_mode(input logic [2:0] m);
    cfg_hash_sel = m;
    cfg_wr       = 1'b1;
    @(posedge clk);
    #1;
    cfg_wr = 1'b0;
    wait_cfg_idle();
    check("cfg_active", 32'(cfg_active), 32'(m));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_tag = '0; out_ready = 1'b1;
    cfg_wr = 1'b0; cfg_hash_sel = '0; err_clr = 1'b0;
    sat_in_valid = 1'b0; sat_in_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_cfg_busy", 32'(cfg_busy), 32'd0);
    check("rst_cfg_active", 32'(cfg_active), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_out_data", 32'({out_module_id, out_local_addr, out_tag, out_err}), 32'd0);

    // Identity mode and two-cycle latency
    send(32'h0000_0D23, 4'd5, 3'd3, 10'h123, 1'b0);
    check("latency_cycle1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("latency_cycle2", 32'(out_valid), 32'd1);
    wait_drain();

    // Bit-reverse, rotate, xor-fold, reserved mode
    set_mode(3'd1);
    send(32'h0000_0400, 4'd1, 3'd4, 10'h000, 1'b0);
    send(32'h0000_0D23, 4'd2, 3'd6, 10'h123, 1'b0);
    wait_drain();
    set_mode(3'd2);
    send(32'h0000_0400, 4'd3, 3'd2, 10'h000, 1'b0);
    send(32'h0000_0D23, 4'd4, 3'd6, 10'h123, 1'b0);
    send(32'h0000_1C07, 4'd6, 3'd7, 10'h007, 1'b0);
    wait_drain();
    set_mode(3'd3);
    send(32'h0000_0D23, 4'd7, 3'd0, 10'h123, 1'b0);
    send(32'h0000_0AAA, 4'd8, 3'd6, 10'h2AA, 1'b0);
    send(32'h0000_0400, 4'd9, 3'd1, 10'h000, 1'b0);
    wait_drain();
    set_mode(3'd5);
    send(32'h0000_0400, 4'd10, 3'd1, 10'h000, 1'b0);
    send(32'h0000_0AAA, 4'd11, 3'd2, 10'h2AA, 1'b0);
    wait_drain();

    // Out of range and error counter
    set_mode(3'd0);
    send(32'h0000_2000, 4'd12, 3'd0, 10'h000, 1'b1);
    wait_drain();
    check("err_cnt_1", 32'(err_cnt), 32'd1);
    send(32'h8000_0D23, 4'd13, 3'd0, 10'h000, 1'b1);
    wait_drain();
    check("err_cnt_2", 32'(err_cnt), 32'd2);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("err_cnt_clr", 32'(err_cnt), 32'd0);

    // Saturation on the narrow-counter instance
    sat_in_addr  = 32'h0000_2000;
    sat_in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sat_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("sat_err_cnt_full", 32'(sat_err_cnt), 32'd3);
    sat_in_valid = 1'b1;
    @(posedge clk);
    #1;
    sat_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("sat_err_cnt_hold", 32'(sat_err_cnt), 32'd3);

    // Backpressure: two held, third waits, all delivered in order
    out_ready = 1'b0;
    fork
      begin
        send(32'h0000_0400, 4'd1, 3'd1, 10'h000, 1'b0);
        send(32'h0000_0D23, 4'd2, 3'd3, 10'h123, 1'b0);
        send(32'h0000_0AAA, 4'd3, 3'd2, 10'h2AA, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_queue_depth", 32'(exp_q.size()), 32'd2);
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Config change while both stages are full
    out_ready = 1'b0;
    send(32'h0000_0400, 4'd4, 3'd1, 10'h000, 1'b0);
    send(32'h0000_0D23, 4'd5, 3'd3, 10'h123, 1'b0);
    cfg_hash_sel = 3'd1;
    cfg_wr       = 1'b1;
    @(posedge clk);
    #1;
    cfg_wr = 1'b0;
    check("cfg_busy_set", 32'(cfg_busy), 32'd1);
    check("cfg_in_ready_low", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("cfg_still_busy", 32'(cfg_busy), 32'd1);
    check("cfg_active_old", 32'(cfg_active), 32'd0);
    out_ready = 1'b1;
    wait_cfg_idle();
    check("cfg_active_new", 32'(cfg_active), 32'd1);
    wait_drain();
    send(32'h0000_0400, 4'd6, 3'd4, 10'h000, 1'b0);
    wait_drain();

    // Reset mid-operation discards in-flight data and the pending change
    out_ready = 1'b0;
    send(32'h0000_1C07, 4'd7, 3'd7, 10'h007, 1'b0);
    cfg_hash_sel = 3'd2;
    cfg_wr       = 1'b1;
    @(posedge clk);
    #1;
    cfg_wr = 1'b0;
    check("pre_rst_cfg_busy", 32'(cfg_busy), 32'd1);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_cfg_busy", 32'(cfg_busy), 32'd0);
    check("midrst_cfg_active", 32'(cfg_active), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    send(32'h0000_0400, 4'd8, 3'd1, 10'h000, 1'b0);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
